led_pwm_ctrl: RTL and testbench
===============================

# led_pwm_ctrl

Parametrised successor to the lab push-button/LED brightness block: four debounced buttons step a signed display value and a brightness level, and the value's bits drive N_LED PWM-dimmed LEDs. New over the previous generation: LED count, PWM period, level count and debounce time are parameters. The block also adds hold-to-auto-repeat on the value buttons, selectable saturate/wrap arithmetic, cancellation of simultaneous opposing presses, and glitch-free duty updates at period boundaries. It sits between the board button pins and the user LEDs.

## Interface
- N_LED, 4: LED count and width of the signed value register (≥2)
- PERIOD, 1_000_000: PWM period in clk cycles; must be a multiple of N_LEVEL
- N_LEVEL, 5: number of brightness levels (≥2)
- DEB_CYCLES, 1_500_000: consecutive stable synchronised samples needed to accept a button change (≥1)
- REPEAT_DELAY, 50_000_000: hold time before auto-repeat starts; 0 disables repeat
- REPEAT_RATE, 10_000_000: cycles between repeat events (≥1)
- WRAP, 0: 0 = value saturates, 1 = value wraps two's-complement
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- usr_btn  in  4  raw buttons, active high; [0] value−1, [1] value+1, [2] level−1, [3] level+1
- usr_led  out  N_LED  PWM LED drive
- value  out  N_LED  signed display value
- level  out  $clog2(N_LEVEL)  current brightness level

## Operation
- Reset: usr_led=0, value=0, level=0, PWM counter=0, latched threshold=thr(0), debounced states=0, repeat timers=0.
- Per button: 2-FF synchroniser → stability counter. The debounced state flips when DEB_CYCLES consecutive synchronised samples differ from it. A 0→1 flip emits a 1-cycle press event. Shorter glitches are ignored.
- Auto-repeat (buttons 0/1 only, REPEAT_DELAY≠0):
  - After a press, if the debounced state stays 1 for REPEAT_DELAY cycles, emit an event.
  - Then emit one event every REPEAT_RATE cycles while held.
  - Release stops repeat immediately.
- Value update: inc xor dec event → value±1. Both in the same cycle → no change.
  - WRAP=0: clamp to [−2^(N_LED−1), 2^(N_LED−1)−1].
  - WRAP=1: modular.
- Level update: up xor down event → level±1, clamped to [0, N_LEVEL−1]; never wraps. Both in the same cycle → no change.
- Level and value events are independent and may apply in the same cycle.
- PWM: counter runs 0..PERIOD−1, then wraps to 0.
  - thr(l) = (l+1)·PERIOD/N_LEVEL.
  - The latched threshold loads thr(level) only in the cycle the counter is PERIOD−1, so a level change takes effect from the next period start.
  - usr_led[i] = value[i] & (counter < latched threshold), registered.
- Top level gives 100% duty: LED continuously on while its bit is set.

## Timing
- Raw press (stable) → press event: DEB_CYCLES+2 cycles. Event → value/level register: +1 cycle.
- Value change → usr_led reflects the new bit pattern: +1 cycle. No period alignment for value.
- Level change → duty change at the next counter wrap (≤PERIOD cycles), then +1 cycle registered output.
- Reset asserted mid-debounce, mid-repeat or mid-period: all state returns to reset values asynchronously. After deassertion, the first event needs a full fresh debounce.
- A button held through reset release must be debounced from zero: one press event after DEB_CYCLES+2 cycles.

## Structure
- Package led_pwm_pkg holds:
  - button index constants BTN_DEC=0, BTN_INC=1, BTN_LVL_DN=2, BTN_LVL_UP=3;
  - function thr(level, PERIOD, N_LEVEL);
  - function sat_step(value, dir, WRAP).
- Sub-module btn_debounce (sync, stability counter, press pulse, optional repeat via parameters). Instantiate it 4×: repeat enabled on indices 0/1 only.
- led_pwm_ctrl holds the value/level registers, PWM counter, threshold latch and output register.

## Test plan
Bench parameters: N_LED=4, PERIOD=20, N_LEVEL=5, DEB_CYCLES=4, REPEAT_DELAY=16, REPEAT_RATE=8, WRAP=0 unless noted.
- Reset → usr_led=0, value=0, level=0. Press btn1 clean for 10 cycles → value=1 exactly 7 cycles after the rise. Then usr_led[0] high for 4 of every 20 cycles.
- btn1 pulsed for 3 cycles, then low → no event, value unchanged. Bounce 1-0-1-0 then stable 1 → exactly one increment.
- Hold btn1 from value=0 → increments at press, then +16, then every 8 cycles; saturates at 7. WRAP=1: 7→−8.
- btn3 pressed 6 times → level 0→4 and clamps; usr_led[0] duty 20/20. A level change mid-period must not alter the duty until the counter wraps.
- btn0 and btn1 pressed in the same cycle → value unchanged. btn2 and btn3 in the same cycle → level unchanged.
- Assert reset during auto-repeat with value=5, level=3 → all outputs 0 immediately. After release with btn1 still held → value=1 after 7 cycles.

Source files
------------

// File: rtl/led_pwm_pkg.sv
// Shared constants, types and helpers for the LED PWM controller.
// Button map, repeat FSM states, threshold and value step helpers.
package led_pwm_pkg;

  localparam int BTN_DEC    = 0;
  localparam int BTN_INC    = 1;
  localparam int BTN_LVL_DN = 2;
  localparam int BTN_LVL_UP = 3;
  localparam int N_BTN      = 4;

  typedef enum logic [1:0] {
    R_IDLE,
    R_DELAY,
    R_RATE
  } rpt_st_e;

  // On-time of one PWM period for a given level.
  function automatic int thr(
    input int lvl,
    input int period,
    input int n_level
  );
    return (lvl + 1) * (period / n_level);
  endfunction

  // One signed step of a width-bit value, clamped or wrapped.
  function automatic int sat_step(
    input int   v,
    input logic dir,
    input logic wrap,
    input int   width
  );
    int hi;
    int lo;
    int res;
    hi = (1 << (width - 1)) - 1;
    lo = -(1 << (width - 1));
    if (dir) begin
      if (v < hi) res = v + 1;
      else        res = wrap ? lo : hi;
    end else begin
      if (v > lo) res = v - 1;
      else        res = wrap ? hi : lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/led_pwm_ctrl_btn.sv
// One button: 2-FF sync, stability-counter debounce, press pulse.
// Optional hold-to-repeat generates extra events while held.
module btn_debounce
  import led_pwm_pkg::*;
#(
  parameter int DEB_CYCLES   = 4,
  parameter bit REPEAT_EN    = 1'b0,
  parameter int REPEAT_DELAY = 16,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic evt
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
  localparam logic [31:0] DLY_LAST  = 32'(REPEAT_DELAY - 1);
  localparam logic [31:0] RATE_LAST = 32'(REPEAT_RATE - 1);
  localparam bit RPT_ON = REPEAT_EN && (REPEAT_DELAY != 0);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          state;
  logic          flip;
  logic          press;
  logic [31:0]   tmr;
  logic          tmr_hit;
  logic          rpt;
  rpt_st_e       st;
  rpt_st_e       st_next;

  // A change is accepted on its DEB_CYCLES-th consecutive sample.
  assign flip = (sync2 != state) && (cnt == CNT_LAST);

  assign tmr_hit = (st == R_RATE) ? (tmr == RATE_LAST)
                                  : (tmr == DLY_LAST);

  // Two-flop synchroniser for the raw pin.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Count consecutive samples that disagree with the debounced state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (sync2 == state || flip) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Debounced state and a one-cycle pulse on each accepted press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= 1'b0;
      press <= 1'b0;
    end else begin
      press <= flip & sync2;
      if (flip) state <= sync2;
    end
  end

  // Repeat FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= R_IDLE;
    else       st <= st_next;
  end

  // Repeat FSM next state: arm on hold, leave on release.
  always_comb begin
    st_next = st;
    unique case (st)
      R_IDLE: begin
        if (RPT_ON && state && !flip) st_next = R_DELAY;
      end
      R_DELAY: begin
        if (!state || flip)  st_next = R_IDLE;
        else if (tmr_hit)    st_next = R_RATE;
      end
      R_RATE: begin
        if (!state || flip)  st_next = R_IDLE;
      end
      default: st_next = R_IDLE;
    endcase
  end

  // Repeat FSM output: one event each time the active interval expires.
  always_comb begin
    rpt = 1'b0;
    if (st != R_IDLE && state && !flip && tmr_hit) rpt = 1'b1;
  end

  // Interval timer, restarted on entry to a phase and on every event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr <= '0;
    end else if (st == R_IDLE || tmr_hit) begin
      tmr <= '0;
    end else begin
      tmr <= tmr + 32'd1;
    end
  end

  assign evt = press | rpt;

endmodule

// File: rtl/led_pwm_ctrl.sv
// Four debounced buttons step a signed value and a brightness level;
// value bits drive PWM-dimmed LEDs with period-aligned duty changes.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int N_LED        = 4,
  parameter int PERIOD       = 1_000_000,
  parameter int N_LEVEL      = 5,
  parameter int DEB_CYCLES   = 1_500_000,
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int WRAP         = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [3:0]                 usr_btn,
  output logic [N_LED-1:0]           usr_led,
  output logic [N_LED-1:0]           value,
  output logic [$clog2(N_LEVEL)-1:0] level
);

  localparam int LW = $clog2(N_LEVEL);
  localparam int CW = $clog2(PERIOD);
  localparam int TW = CW + 1;
  localparam logic [LW-1:0] LVL_MAX  = LW'(N_LEVEL - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
  localparam logic [TW-1:0] THR_RST  = TW'(thr(0, PERIOD, N_LEVEL));

  logic [N_BTN-1:0] evt;
  logic             inc;
  logic             dec;
  logic             up;
  logic             dn;
  logic [CW-1:0]    cnt;
  logic             wrap_now;
  logic [TW-1:0]    thr_q;
  logic             pwm_on;

  for (genvar i = 0; i < N_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEB_CYCLES   (DEB_CYCLES),
      .REPEAT_EN    (i == BTN_DEC || i == BTN_INC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_RATE  (REPEAT_RATE)
    ) u_deb (
      .clk   (clk),
      .reset (reset),
      .btn   (usr_btn[i]),
      .evt   (evt[i])
    );
  end

  assign inc = evt[BTN_INC];
  assign dec = evt[BTN_DEC];
  assign up  = evt[BTN_LVL_UP];
  assign dn  = evt[BTN_LVL_DN];

  // Signed value steps on exactly one of inc/dec; opposing events cancel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (inc ^ dec) begin
      value <= N_LED'(sat_step(int'($signed(value)), inc,
                               WRAP != 0, N_LED));
    end
  end

  // Brightness level steps and clamps at both ends.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level <= '0;
    end else if (up && !dn && level != LVL_MAX) begin
      level <= level + 1'b1;
    end else if (dn && !up && level != '0) begin
      level <= level - 1'b1;
    end
  end

  assign wrap_now = (cnt == CNT_LAST);

  // Free-running PWM period counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cnt <= '0;
    else if (wrap_now) cnt <= '0;
    else               cnt <= cnt + 1'b1;
  end

  // Threshold only reloads at the period end so duty never glitches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr_q <= THR_RST;
    end else if (wrap_now) begin
      thr_q <= TW'(thr(int'(level), PERIOD, N_LEVEL));
    end
  end

  assign pwm_on = ({1'b0, cnt} < thr_q);

  // Registered LED drive: value bits gated by the PWM phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) usr_led <= '0;
    else       usr_led <= value & {N_LED{pwm_on}};
  end

endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench for led_pwm_ctrl with small parameters.
// A value scoreboard is paired with timed direct checks.
module tb_led_pwm_ctrl;

  localparam int N_LED = 4;
  localparam int PER   = 20;
  localparam int NLV   = 5;
  localparam int DEB   = 4;
  localparam int RDLY  = 16;
  localparam int RRATE = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = '0;
  logic [3:0] btn_w = '0;
  logic [3:0] led;
  logic [3:0] value;
  logic [2:0] level;
  logic [3:0] led_w;
  logic [3:0] value_w;
  logic [2:0] level_w;

  int total = 0;
  int bad = 0;
  int sbq[$];
  logic [3:0] last_v = '0;

  always #5 clk = ~clk;

  led_pwm_ctrl #(
    .N_LED(N_LED), .PERIOD(PER), .N_LEVEL(NLV),
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY),
    .REPEAT_RATE(RRATE), .WRAP(0)
  ) dut (
    .clk(clk), .reset(rst), .usr_btn(btn),
    .usr_led(led), .value(value), .level(level)
  );

  led_pwm_ctrl #(
    .N_LED(N_LED), .PERIOD(PER), .N_LEVEL(NLV),
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY),
    .REPEAT_RATE(RRATE), .WRAP(1)
  ) dut_w (
    .clk(clk), .reset(rst), .usr_btn(btn_w),
    .usr_led(led_w), .value(value_w), .level(level_w)
  );

  task automatic check(input string tag, input int got,
                       input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Every value change must match the next queued expectation.
  always @(negedge clk) begin
    if (value !== last_v) begin
      int e;
      e = (sbq.size() != 0) ? sbq.pop_front() : -1;
      check("sb_value", int'(value), e);
      last_v = value;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int idx, input int hold);
    btn[idx] = 1'b1;
    tick(hold);
    btn[idx] = 1'b0;
    tick(10);
  endtask

  task automatic duty(output int n, input int len);
    n = 0;
    repeat (len) begin
      @(negedge clk);
      n += int'(led[0]);
    end
  endtask

  initial begin
    int n;
    int found;
    int run;
    int low;
    int hi;
    logic prev;

    tick(3);
    check("rst_value", int'(value), 0);
    check("rst_level", int'(level), 0);
    check("rst_led", int'(led), 0);
    rst = 1'b0;
    tick(2);

    // clean press: value 1 exactly 7 cycles after the rise
    sbq.push_back(1);
    btn[1] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) check("inc_early", int'(value), 0);
      if (k == 7) check("inc_lat", int'(value), 1);
    end
    btn[1] = 1'b0;
    tick(12);
    duty(n, 20);
    check("duty_l0", n, 4);
    check("led_hi_off", int'(led[3:1]), 0);

    // short glitch is ignored
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(12);
    check("glitch", int'(value), 1);

    // bounce then stable: one increment
    btn[1] = 1'b1; tick(1);
    btn[1] = 1'b0; tick(1);
    btn[1] = 1'b1; tick(1);
    btn[1] = 1'b0; tick(1);
    sbq.push_back(2);
    btn[1] = 1'b1;
    tick(10);
    btn[1] = 1'b0;
    tick(12);
    check("bounce", int'(value), 2);

    sbq.push_back(0);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(2);

    // hold: press, +16, then every 8; saturate vs wrap
    for (int i = 1; i <= 7; i++) sbq.push_back(i);
    btn[1] = 1'b1;
    btn_w[1] = 1'b1;
    for (int k = 1; k <= 90; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6)  check("hold_k6", int'(value), 0);
      if (k == 7)  check("hold_k7", int'(value), 1);
      if (k == 22) check("hold_k22", int'(value), 1);
      if (k == 23) check("hold_k23", int'(value), 2);
      if (k == 31) check("hold_k31", int'(value), 3);
      if (k == 63) check("hold_k63", int'(value), 7);
      if (k == 90) check("hold_sat", int'(value), 7);
      if (k == 63) check("wrap_k63", int'(value_w), 7);
      if (k == 71) check("wrap_k71", int'(value_w), 8);
      if (k == 87) check("wrap_k87", int'(value_w), 10);
    end
    btn[1] = 1'b0;
    btn_w[1] = 1'b0;
    tick(12);

    // level up six times: clamps at 4, full duty
    for (int i = 0; i < 6; i++) begin
      press(3, 8);
      check("lvl_up", int'(level), (i < 4) ? i + 1 : 4);
    end
    tick(25);
    duty(n, 20);
    check("duty_full", n, 20);

    press(2, 8);
    check("lvl_dn", int'(level), 3);
    tick(25);

    // level change mid-period waits for the counter wrap
    found = 0;
    @(negedge clk);
    prev = led[0];
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!prev && led[0]) begin
        found = 1;
        break;
      end
      prev = led[0];
    end
    check("rise_found", found, 1);
    if (found == 1) begin
      btn[3] = 1'b1;
      run = 1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (!led[0]) break;
        run++;
      end
      check("old_duty", run, 16);
      check("lvl_mid", int'(level), 4);
      low = 1;
      for (int i = 0; i < 30; i++) begin
        @(negedge clk);
        if (led[0]) break;
        low++;
      end
      check("low_run", low, 4);
      hi = 1;
      repeat (19) begin
        @(negedge clk);
        hi += int'(led[0]);
      end
      check("new_duty", hi, 20);
    end
    btn[3] = 1'b0;
    tick(10);

    // opposing presses in the same cycle cancel
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    tick(8);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    tick(10);
    check("opp_value", int'(value), 7);
    btn[2] = 1'b1;
    btn[3] = 1'b1;
    tick(8);
    btn[2] = 1'b0;
    btn[3] = 1'b0;
    tick(10);
    check("opp_level", int'(level), 4);

    for (int i = 0; i < 4; i++) begin
      sbq.push_back(6 - i);
      press(0, 8);
    end
    check("val3", int'(value), 3);
    press(2, 8);
    check("lvl3", int'(level), 3);

    // reset in the repeat phase, button still held afterwards
    sbq.push_back(4);
    sbq.push_back(5);
    btn[1] = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 7)  check("pre_k7", int'(value), 4);
      if (k == 23) check("pre_k23", int'(value), 5);
      if (k == 23) check("pre_lvl", int'(level), 3);
    end
    sbq.push_back(0);
    rst = 1'b1;
    #1;
    check("arst_value", int'(value), 0);
    check("arst_level", int'(level), 0);
    check("arst_led", int'(led), 0);
    check("arst_w_value", int'(value_w), 0);
    check("arst_w_level", int'(level_w), 0);
    check("arst_w_led", int'(led_w), 0);
    tick(3);
    sbq.push_back(1);
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k == 6) check("post_k6", int'(value), 0);
      if (k == 7) check("post_k7", int'(value), 1);
    end
    btn[1] = 1'b0;
    tick(12);
    check("sb_left", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
